// File: rtl/arith_seq_unit.sv
// rtl/arith_seq_unit.sv - sequential arithmetic unit: single-cycle add/sub family, iterative MUL/DIV
module arith_seq_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic [2:0]       F,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic [WIDTH-1:0] Out_hi,
  output logic [5:0]       Status
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] out_q, out_d, out_hi_q, out_hi_d;
  logic [5:0]       st_q, st_d;
  logic             div_q, div_d;

  // Single-cycle add/sub family, evaluated on the live inputs at acceptance
  logic             is_inc_dec, is_sub, cin_eff, alu_v, alu_af;
  logic [WIDTH-1:0] b_eff, alu_r;
  logic [WIDTH:0]   alu_w;

  always_comb begin
    is_inc_dec = (F == 3'b001) || (F == 3'b011);
    is_sub     = (F == 3'b011) || (F[2:1] == 2'b11);
    cin_eff    = ((F == 3'b101) || (F == 3'b111)) & Cin;
    b_eff      = is_inc_dec ? WIDTH'(1) : B;
    if (is_sub) begin
      alu_w = {1'b0, A} - {1'b0, b_eff} - {{WIDTH{1'b0}}, cin_eff};
    end else begin
      alu_w = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin_eff};
    end
    alu_r = alu_w[WIDTH-1:0];
    if (is_sub) begin
      alu_v = (A[WIDTH-1] != b_eff[WIDTH-1]) && (alu_r[WIDTH-1] != A[WIDTH-1]);
    end else begin
      alu_v = (A[WIDTH-1] == b_eff[WIDTH-1]) && (alu_r[WIDTH-1] != A[WIDTH-1]);
    end
    // Carry (or borrow) into bit 4 is recovered from the bit-4 sum identity
    alu_af = A[4] ^ b_eff[4] ^ alu_r[4];
  end

  // One shift-add / restoring-divide step on the {hi,lo} work pair
  logic [WIDTH:0] mul_sum, div_sh, div_tr;
  logic           div_ok;

  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    div_sh  = {hi_q, lo_q[WIDTH-1]};
    div_tr  = div_sh - {1'b0, b_q};
    div_ok  = ~div_tr[WIDTH];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    out_d    = out_q;
    out_hi_d = out_hi_q;
    st_d     = st_q;
    div_d    = div_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d   = A;
          b_d   = B;
          cnt_d = '0;
          div_d = (F == 3'b010);
          if (F == 3'b000 || F == 3'b010) begin
            state_d = S_BUSY;
            hi_d    = '0;
            lo_d    = (F == 3'b000) ? B : A;
          end else begin
            state_d  = S_DONE;
            out_d    = alu_r;
            out_hi_d = '0;
            st_d     = {alu_w[WIDTH], alu_r == '0, alu_r[WIDTH-1], alu_v, ~^alu_r, alu_af};
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + CW'(1);
        if (div_q) begin
          hi_d = div_ok ? div_tr[WIDTH-1:0] : div_sh[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], div_ok};
        end else begin
          hi_d = mul_sum[WIDTH:1];
          lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
        if (cnt_q == LAST) begin
          state_d  = S_DONE;
          out_d    = lo_d;
          out_hi_d = hi_d;
          // Divide by zero falls out of the restoring loop as all-ones / A
          if (div_q) begin
            st_d = {1'b0, lo_d == '0, lo_d[WIDTH-1], b_q == '0, ~^lo_d, 1'b0};
          end else begin
            st_d = {hi_d != '0, (hi_d == '0) && (lo_d == '0), hi_d[WIDTH-1],
                    hi_d != '0, ~^lo_d, 1'b0};
          end
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      out_q    <= '0;
      out_hi_q <= '0;
      st_q     <= '0;
      div_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      out_q    <= out_d;
      out_hi_q <= out_hi_d;
      st_q     <= st_d;
      div_q    <= div_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign Out       = out_q;
  assign Out_hi    = out_hi_q;
  assign Status    = st_q;

endmodule

// File: tb/tb_arith_seq_unit.sv
// tb/tb_arith_seq_unit.sv - directed self-checking bench for arith_seq_unit
module tb_arith_seq_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] A = '0, B = '0;
  logic        Cin = 1'b0;
  logic [2:0]  F = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] Out, Out_hi;
  logic [5:0]  Status;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] exp_out = '0, exp_hi = '0;
  logic [5:0]  exp_st = '0;

  arith_seq_unit #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin), .F(F), .out_valid(out_valid), .out_ready(out_ready),
    .Out(Out), .Out_hi(Out_hi), .Status(Status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Result model from plain integer arithmetic: returns {Out, Out_hi, C,Z,N,V,P,Af}
  function automatic logic [37:0] model(input logic [2:0] f, input logic [15:0] a, b, input logic c);
    longint ua, ub, bb, cc, r, sa, sb, sr;
    logic [15:0] o, h;
    logic cf, zf, nf, vf, pf, af;
    ua = longint'(a); ub = longint'(b);
    sa = longint'($signed(a));
    af = 1'b0;
    if (f == 3'd0) begin
      r = ua * ub;
      o = r[15:0]; h = r[31:16];
      cf = (h != 0); vf = cf; zf = (r == 0); nf = h[15];
    end else if (f == 3'd2) begin
      if (ub == 0) begin
        o = 16'hFFFF; h = a; vf = 1'b1;
      end else begin
        r = ua / ub; o = r[15:0];
        r = ua % ub; h = r[15:0];
        vf = 1'b0;
      end
      cf = 1'b0; zf = (o == 0); nf = o[15];
    end else begin
      bb = (f == 3'd1 || f == 3'd3) ? 1 : ub;
      sb = (f == 3'd1 || f == 3'd3) ? 1 : longint'($signed(b));
      cc = (f == 3'd5 || f == 3'd7) ? longint'(c) : 0;
      if (f == 3'd3 || f == 3'd6 || f == 3'd7) begin
        r = ua - bb - cc; cf = (r < 0); sr = sa - sb - cc;
        af = ((ua % 16) < (bb % 16 + cc));
      end else begin
        r = ua + bb + cc; cf = (r > 65535); sr = sa + sb + cc;
        af = ((ua % 16 + bb % 16 + cc) > 15);
      end
      vf = (sr > 32767) || (sr < -32768);
      o = r[15:0]; h = 16'h0; zf = (o == 0); nf = o[15];
    end
    pf = ($countones(o) % 2) == 0;
    return {o, h, cf, zf, nf, vf, pf, af};
  endfunction

  // Whenever a result is presented it must match the model and block new requests
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      chk("out", 64'(Out), 64'(exp_out));
      chk("out_hi", 64'(Out_hi), 64'(exp_hi));
      chk("status", 64'(Status), 64'(exp_st));
      chk("in_ready_in_done", 64'(in_ready), 64'(0));
    end
  end

  task automatic run_op(input logic [2:0] f, input logic [15:0] a, b, input logic c, input int hold);
    int lat;
    bit seen;
    {exp_out, exp_hi, exp_st} = model(f, a, b, c);
    @(negedge clk);
    chk("in_ready_idle", 64'(in_ready), 64'(1));
    F = f; A = a; B = b; Cin = c; in_valid = 1'b1;
    @(posedge clk);
    lat = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      lat++;
      in_valid = 1'b0;
      A = 16'($urandom); B = 16'($urandom); Cin = 1'($urandom); F = 3'($urandom);
      seen = out_valid;
    end
    chk("done_seen", 64'(seen), 64'(1));
    chk("latency", 64'(lat), (f == 3'd0 || f == 3'd2) ? 64'(17) : 64'(1));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      A = 16'($urandom); B = 16'($urandom); Cin = 1'($urandom); F = 3'($urandom);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ack_out_valid", 64'(out_valid), 64'(0));
    chk("ack_in_ready", 64'(in_ready), 64'(1));
    out_ready = 1'b0;
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [15:0] a, b;
    logic        c;
    int          hold;
  } vec_t;

  vec_t vecs[$];
  logic [37:0] m;
  int stray;

  initial begin
    // Hand-computed anchors for the model itself
    m = model(3'd4, 16'h7FFF, 16'h0001, 1'b0); chk("pin_add", 64'(m), 64'({16'h8000, 16'h0000, 6'b001101}));
    m = model(3'd7, 16'h0000, 16'h0000, 1'b1); chk("pin_sbb", 64'(m), 64'({16'hFFFF, 16'h0000, 6'b101011}));
    m = model(3'd0, 16'hFFFF, 16'hFFFF, 1'b0); chk("pin_mul", 64'(m), 64'({16'h0001, 16'hFFFE, 6'b101100}));
    m = model(3'd2, 16'h0064, 16'h0007, 1'b0); chk("pin_div", 64'(m), 64'({16'h000E, 16'h0002, 6'b000000}));
    m = model(3'd2, 16'h1234, 16'h0000, 1'b0); chk("pin_div0", 64'(m), 64'({16'hFFFF, 16'h1234, 6'b001110}));
    m = model(3'd1, 16'hFFFF, 16'h0000, 1'b0); chk("pin_inc", 64'(m), 64'({16'h0000, 16'h0000, 6'b110011}));

    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out", 64'({Out, Out_hi, Status}), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    vecs.push_back('{3'd4, 16'h7FFF, 16'h0001, 1'b0, 0});
    vecs.push_back('{3'd7, 16'h0000, 16'h0000, 1'b1, 0});
    vecs.push_back('{3'd0, 16'hFFFF, 16'hFFFF, 1'b0, 5});
    vecs.push_back('{3'd2, 16'h0064, 16'h0007, 1'b0, 0});
    vecs.push_back('{3'd2, 16'h1234, 16'h0000, 1'b0, 2});
    vecs.push_back('{3'd1, 16'hFFFF, 16'h0000, 1'b0, 0});
    vecs.push_back('{3'd3, 16'h8000, 16'h0000, 1'b1, 0});
    vecs.push_back('{3'd5, 16'hFFFF, 16'h0000, 1'b1, 1});
    vecs.push_back('{3'd6, 16'h1234, 16'h5678, 1'b1, 0});
    vecs.push_back('{3'd4, 16'h0001, 16'h0001, 1'b1, 0});
    vecs.push_back('{3'd0, 16'h1234, 16'h0000, 1'b0, 0});
    vecs.push_back('{3'd0, 16'h00FF, 16'h0101, 1'b0, 0});
    vecs.push_back('{3'd6, 16'h8000, 16'h0001, 1'b0, 0});
    vecs.push_back('{3'd2, 16'hFFFF, 16'h0001, 1'b0, 0});
    foreach (vecs[i]) run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].hold);

    // Reset in the middle of a multiply discards it
    @(negedge clk);
    F = 3'd0; A = 16'h1357; B = 16'h2468; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out", 64'({Out, Out_hi, Status}), 64'(0));
    chk("midrst_in_ready", 64'(in_ready), 64'(1));
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) stray++;
    end
    chk("midrst_no_result", 64'(stray), 64'(0));

    // Request held through reset release is taken on the first rising edge
    {exp_out, exp_hi, exp_st} = model(3'd4, 16'h00F0, 16'h0010, 1'b0);
    rst_n = 1'b0;
    F = 3'd4; A = 16'h00F0; B = 16'h0010; in_valid = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("first_edge_accept", 64'(out_valid), 64'(1));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("first_edge_ack", 64'(in_ready), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/arith_seq_unit.md
ARITH_SEQ_UNIT -- requirements
Module: arith_seq_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand/result width, legal range 8..64.
REQ-002 The block SHALL have port clk, input, 1, single clock, all state updates on rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1, operation request.
REQ-005 The block SHALL have port in_ready, output, 1, block can accept a request.
REQ-006 The block SHALL have ports A and B, input, WIDTH each, operands.
REQ-007 The block SHALL have port Cin, input, 1, carry/borrow in for ADC/SBB.
REQ-008 The block SHALL have port F, input, 3, opcode: 000 MUL, 001 INC, 010 DIV, 011 DEC, 100 ADD, 101 ADC, 110 SUB, 111 SBB.
REQ-009 The block SHALL have port out_valid, output, 1, result held and valid.
REQ-010 The block SHALL have port out_ready, input, 1, consumer accepts result.
REQ-011 The block SHALL have ports Out and Out_hi, output, WIDTH each, result low / high (product high or remainder; 0 for other ops).
REQ-012 The block SHALL have port Status, output, 6, {C,Z,N,V,P,Af} of the held result.

Function
REQ-013 States SHALL be IDLE, BUSY, DONE; in_ready SHALL be 1 only in IDLE.
REQ-014 In IDLE with in_valid=1, the block SHALL latch A, B, Cin, F on that edge.
REQ-015 INC/DEC/ADD/ADC/SUB/SBB SHALL go IDLE->DONE, out_valid=1 in the cycle after acceptance (latency 1).
REQ-016 MUL and DIV SHALL go IDLE->BUSY, iterate one bit per cycle for exactly WIDTH cycles, then enter DONE (out_valid asserted WIDTH+1 cycles after acceptance).
REQ-017 MUL SHALL be unsigned shift-add; {Out_hi,Out} = A*B, 2*WIDTH bits.
REQ-018 DIV SHALL be unsigned restoring; Out = A/B, Out_hi = A%B.
REQ-019 DIV with B=0 SHALL return Out=all ones, Out_hi=A, V=1, after the same WIDTH+1 latency.
REQ-020 Add-type ops SHALL compute WIDTH+1-bit sums: INC A+1, ADD A+B, ADC A+B+Cin; C = bit WIDTH.
REQ-021 Sub-type ops SHALL compute DEC A-1, SUB A-B, SBB A-B-Cin; C = borrow (bit WIDTH of WIDTH+1-bit difference).
REQ-022 V SHALL be signed two's-complement overflow of the actual operation (operand B = 1 for INC/DEC).
REQ-023 Af SHALL be carry out of bit 3 (add-type) or borrow into bit 4 (sub-type); 0 for MUL/DIV.
REQ-024 Z SHALL be 1 when Out=0 (MUL: full 2*WIDTH product =0); N = Out[WIDTH-1] (MUL: Out_hi[WIDTH-1]); P = 1 when Out has an even number of ones.
REQ-025 For MUL, C and V SHALL both be 1 when Out_hi != 0; for DIV, C=0 and V per REQ-019.
REQ-026 In DONE, Out, Out_hi, Status, out_valid SHALL hold stable until out_valid&out_ready; then next state SHALL be IDLE, out_valid=0.
REQ-027 Input changes while not in IDLE SHALL have no effect on the operation in progress.
REQ-028 in_valid in BUSY/DONE SHALL be ignored (not queued); requester must hold until in_ready.

Reset
REQ-029 rst_n=0 SHALL immediately force state IDLE, in_ready=1, out_valid=0, Out=0, Out_hi=0, Status=0, iteration counter=0, regardless of clk.
REQ-030 Reset asserted mid-MUL/DIV or in DONE SHALL discard the operation; no result SHALL be presented after release.
REQ-031 After rst_n deassertion, first acceptance SHALL be possible on the first rising edge.

Verification
REQ-032 WIDTH=16, ADD A=7FFF B=0001 -> 1 cycle later Out=8000, Status C=0 Z=0 N=1 V=1 P=0 Af=1.
REQ-033 WIDTH=16, SBB A=0000 B=0000 Cin=1 -> Out=FFFF, C=1, N=1, V=0, P=1, Af=1.
REQ-034 WIDTH=16, MUL A=FFFF B=FFFF -> out_valid exactly 17 cycles after acceptance, Out_hi=FFFE, Out=0001, C=V=1.
REQ-035 WIDTH=16, DIV A=0064 B=0007 -> Out=000E, Out_hi=0002; DIV A=1234 B=0 -> Out=FFFF, Out_hi=1234, V=1.
REQ-036 Hold out_ready=0 for 5 cycles in DONE with inputs toggling -> outputs stable, in_ready=0; then out_ready=1 -> IDLE next cycle.
REQ-037 Assert rst_n=0 at BUSY cycle 8 of a MUL -> outputs zero immediately; after release no out_valid until a new request.
